// File: rtl/riscv_pkg.sv
// Shared core definitions: fetch FSM encoding, instruction field positions
// and the base-ISA opcodes used by the main decoder.
package riscv_pkg;

   typedef logic [1:0] fetch_state_t;

   localparam fetch_state_t FETCH    = 2'd0;
   localparam fetch_state_t WAIT_RSP = 2'd1;
   localparam fetch_state_t ISSUE    = 2'd2;
   localparam fetch_state_t HALT     = 2'd3;

   localparam int unsigned OPCODE_LSB = 0;
   localparam int unsigned FUNCT3_LSB = 12;
   localparam int unsigned FUNCT7_LSB = 25;

   localparam logic [6:0] OP_LUI    = 7'h37;
   localparam logic [6:0] OP_AUIPC  = 7'h17;
   localparam logic [6:0] OP_JAL    = 7'h6F;
   localparam logic [6:0] OP_JALR   = 7'h67;
   localparam logic [6:0] OP_BRANCH = 7'h63;
   localparam logic [6:0] OP_LOAD   = 7'h03;
   localparam logic [6:0] OP_STORE  = 7'h23;
   localparam logic [6:0] OP_IMM    = 7'h13;
   localparam logic [6:0] OP_REG    = 7'h33;
   localparam logic [6:0] OP_SYSTEM = 7'h73;

   function automatic logic word_aligned(input logic [1:0] addr_lsbs);
      return addr_lsbs == 2'b00;
   endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: single-outstanding imem request, holds one
// instruction for decode, applies redirects on retire, flags faults.
module fetch_unit
   import riscv_pkg::*;
#(
   parameter int unsigned XLEN           = 32,
   parameter logic [31:0] RESET_PC       = 32'h0000_0000,
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned TIMEOUT_WIDTH  = 8,
   parameter int unsigned OPCODE_WIDTH   = 7,
   parameter int unsigned FUNCT3_WIDTH   = 3,
   parameter int unsigned FUNCT7_WIDTH   = 7
) (
   input  logic                    clk,
   input  logic                    rst_n,
   output logic                    imem_req_valid,
   input  logic                    imem_req_ready,
   output logic [XLEN-1:0]         imem_addr,
   input  logic                    imem_rsp_valid,
   input  logic [XLEN-1:0]         imem_rsp_data,
   output logic [XLEN-1:0]         instr,
   output logic                    instr_valid,
   input  logic                    instr_ready,
   output logic [OPCODE_WIDTH-1:0] opcode,
   output logic [FUNCT3_WIDTH-1:0] funct3,
   output logic [FUNCT7_WIDTH-1:0] funct7,
   output logic [XLEN-1:0]         pc,
   output logic [XLEN-1:0]         pc_plus4,
   input  logic                    PCSrc,
   input  logic [XLEN-1:0]         PCTarget,
   output logic                    fault_misaligned,
   output logic                    fault_timeout,
   output logic                    halted,
   output logic [31:0]             instret
);

   fetch_state_t             state_q, state_d;
   logic [XLEN-1:0]          pc_q, pc_d;
   logic [XLEN-1:0]          instr_q, instr_d;
   logic [TIMEOUT_WIDTH-1:0] wait_cnt_q, wait_cnt_d;
   logic [31:0]              instret_q, instret_d;
   logic                     fault_mis_q, fault_mis_d;
   logic                     fault_tmo_q, fault_tmo_d;
   logic [XLEN-1:0]          pc_plus4_w;

   assign pc_plus4_w = pc_q + XLEN'(4);

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      instr_d     = instr_q;
      wait_cnt_d  = wait_cnt_q;
      instret_d   = instret_q;
      fault_mis_d = fault_mis_q;
      fault_tmo_d = fault_tmo_q;
      case (state_q)
         FETCH: begin
            if (imem_req_ready) begin
               state_d    = WAIT_RSP;
               wait_cnt_d = '0;
            end
         end
         WAIT_RSP: begin
            // A response in the final permitted cycle still wins over the timeout.
            if (imem_rsp_valid) begin
               instr_d = imem_rsp_data;
               state_d = ISSUE;
            end else if (wait_cnt_q == TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1)) begin
               fault_tmo_d = 1'b1;
               state_d     = HALT;
            end else begin
               wait_cnt_d = wait_cnt_q + 1'b1;
            end
         end
         ISSUE: begin
            if (instr_ready) begin
               instret_d = instret_q + 32'd1;
               if (!PCSrc) begin
                  pc_d    = pc_plus4_w;
                  state_d = FETCH;
               end else if (word_aligned(PCTarget[1:0])) begin
                  pc_d    = PCTarget;
                  state_d = FETCH;
               end else begin
                  fault_mis_d = 1'b1;
                  state_d     = HALT;
               end
            end
         end
         default: state_d = HALT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= FETCH;
         pc_q        <= XLEN'(RESET_PC);
         instr_q     <= '0;
         wait_cnt_q  <= '0;
         instret_q   <= '0;
         fault_mis_q <= 1'b0;
         fault_tmo_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         instr_q     <= instr_d;
         wait_cnt_q  <= wait_cnt_d;
         instret_q   <= instret_d;
         fault_mis_q <= fault_mis_d;
         fault_tmo_q <= fault_tmo_d;
      end
   end

   assign imem_req_valid   = (state_q == FETCH);
   assign imem_addr        = pc_q;
   assign instr_valid      = (state_q == ISSUE);
   assign halted           = (state_q == HALT);
   assign instr            = instr_q;
   assign opcode           = instr_q[OPCODE_LSB +: OPCODE_WIDTH];
   assign funct3           = instr_q[FUNCT3_LSB +: FUNCT3_WIDTH];
   assign funct7           = instr_q[FUNCT7_LSB +: FUNCT7_WIDTH];
   assign pc               = pc_q;
   assign pc_plus4         = pc_plus4_w;
   assign fault_misaligned = fault_mis_q;
   assign fault_timeout    = fault_tmo_q;
   assign instret          = instret_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed table, multi-cycle corner sequences and a
// randomized run against a program-order reference model.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic [31:0] instr;
   logic        instr_valid;
   logic        instr_ready;
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        PCSrc;
   logic [31:0] PCTarget;
   logic        fault_misaligned;
   logic        fault_timeout;
   logic        halted;
   logic [31:0] instret;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   fetch_unit #(
      .XLEN(32), .RESET_PC(32'h0000_0000), .TIMEOUT_CYCLES(255), .TIMEOUT_WIDTH(8),
      .OPCODE_WIDTH(7), .FUNCT3_WIDTH(3), .FUNCT7_WIDTH(7)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
      .opcode(opcode), .funct3(funct3), .funct7(funct7),
      .pc(pc), .pc_plus4(pc_plus4), .PCSrc(PCSrc), .PCTarget(PCTarget),
      .fault_misaligned(fault_misaligned), .fault_timeout(fault_timeout),
      .halted(halted), .instret(instret)
   );

   // Instruction memory contents: address 0 holds addi x1,x0,5.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return 32'h0050_0093 ^ (a * 32'h9E37_79B1);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
      instr_ready = 1'b0; PCSrc = 1'b0; PCTarget = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Entered at a negedge in FETCH; leaves at a negedge in ISSUE.
   task automatic fetch_one(input int req_delay, input int rsp_delay,
                            input logic [31:0] exp_pc, input bit stray);
      logic [31:0] w;
      w = mem_word(exp_pc);
      for (int i = 0; i < req_delay; i++) begin
         chk("req_valid_hold", 32'(imem_req_valid), 32'd1);
         chk("addr_hold", imem_addr, exp_pc);
         imem_rsp_valid = stray & 1'($urandom);
         imem_rsp_data  = $urandom;
         @(negedge clk);
      end
      imem_rsp_valid = 1'b0;
      chk("req_valid", 32'(imem_req_valid), 32'd1);
      chk("imem_addr", imem_addr, exp_pc);
      imem_req_ready = 1'b1;
      @(negedge clk);
      imem_req_ready = 1'b0;
      chk("req_valid_drop", 32'(imem_req_valid), 32'd0);
      chk("instr_valid_early", 32'(instr_valid), 32'd0);
      for (int i = 1; i < rsp_delay; i++) @(negedge clk);
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = w;
      @(negedge clk);
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
      chk("instr_valid", 32'(instr_valid), 32'd1);
      chk("pc", pc, exp_pc);
      chk("instr", instr, w);
      chk("opcode", 32'(opcode), 32'(w[6:0]));
      chk("funct3", 32'(funct3), 32'(w[14:12]));
      chk("funct7", 32'(funct7), 32'(w[31:25]));
      chk("pc_plus4_model", pc_plus4, exp_pc + 32'd4);
   endtask

   // Entered at a negedge in ISSUE; leaves at the negedge after the retire edge.
   task automatic retire(input int delay, input logic src, input logic [31:0] tgt,
                         input logic [31:0] exp_instr, input bit stray);
      for (int i = 0; i < delay; i++) begin
         chk("issue_hold", 32'(instr_valid), 32'd1);
         chk("instr_stable", instr, exp_instr);
         imem_rsp_valid = stray & 1'($urandom);
         imem_rsp_data  = $urandom;
         @(negedge clk);
      end
      imem_rsp_valid = 1'b0;
      instr_ready = 1'b1; PCSrc = src; PCTarget = tgt;
      @(negedge clk);
      instr_ready = 1'b0; PCSrc = 1'($urandom); PCTarget = $urandom;
   endtask

   typedef struct {
      logic        src;
      logic [31:0] tgt;
      logic [31:0] exp_pc;
      logic [31:0] exp_pc4;
   } vec_t;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vec_t        tbl [7];
      logic [31:0] model_pc, tmp, tgt, saved_pc, saved_ir;
      logic [31:0] model_ir;
      logic        src;

      tbl[0] = '{1'b0, 32'h0,         32'h0,         32'h4};
      tbl[1] = '{1'b0, 32'h0,         32'h4,         32'h8};
      tbl[2] = '{1'b0, 32'h0,         32'h8,         32'hC};
      tbl[3] = '{1'b1, 32'h40,        32'hC,         32'h10};
      tbl[4] = '{1'b1, 32'hFFFF_FFFC, 32'h40,        32'h44};
      tbl[5] = '{1'b0, 32'h0,         32'hFFFF_FFFC, 32'h0};
      tbl[6] = '{1'b0, 32'h0,         32'h0,         32'h4};

      // Reset state
      rst_n = 1'b0;
      imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
      instr_ready = 1'b0; PCSrc = 1'b0; PCTarget = '0;
      @(negedge clk);
      chk("rst_pc", pc, 32'h0);
      chk("rst_instr", instr, 32'h0);
      chk("rst_instr_valid", 32'(instr_valid), 32'd0);
      chk("rst_instret", instret, 32'd0);
      chk("rst_halted", 32'(halted), 32'd0);
      chk("rst_faults", {30'd0, fault_misaligned, fault_timeout}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed table: sequential, redirect, wrap-around
      for (int i = 0; i < 7; i++) begin
         fetch_one(0, 1, tbl[i].exp_pc, 1'b0);
         chk("tbl_pc_plus4", pc_plus4, tbl[i].exp_pc4);
         if (i == 0) begin
            chk("tbl_opcode0", 32'(opcode), 32'h13);
            chk("tbl_funct3_0", 32'(funct3), 32'h0);
         end
         if (i == 3) chk("tbl_instret3", instret, 32'd3);
         retire(0, tbl[i].src, tbl[i].tgt, mem_word(tbl[i].exp_pc), 1'b0);
      end
      chk("tbl_instret_end", instret, 32'd7);

      // Misaligned redirect halts with pc held and the instruction counted
      fetch_one(0, 1, 32'h4, 1'b0);
      saved_ir = instret;
      retire(0, 1'b1, 32'h42, mem_word(32'h4), 1'b0);
      chk("mis_fault", 32'(fault_misaligned), 32'd1);
      chk("mis_halted", 32'(halted), 32'd1);
      chk("mis_pc", pc, 32'h4);
      chk("mis_instret", instret, saved_ir + 32'd1);
      chk("mis_timeout_clear", 32'(fault_timeout), 32'd0);
      imem_req_ready = 1'b1; imem_rsp_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("mis_no_req", 32'(imem_req_valid), 32'd0);
         chk("mis_no_issue", 32'(instr_valid), 32'd0);
      end
      imem_req_ready = 1'b0; imem_rsp_valid = 1'b0;

      // Timeout after 255 silent wait cycles
      do_reset();
      imem_req_ready = 1'b1;
      @(negedge clk);
      imem_req_ready = 1'b0;
      repeat (254) @(negedge clk);
      chk("tmo_not_yet", {30'd0, halted, fault_timeout}, 32'd0);
      @(negedge clk);
      chk("tmo_fault", 32'(fault_timeout), 32'd1);
      chk("tmo_halted", 32'(halted), 32'd1);
      chk("tmo_no_req", 32'(imem_req_valid), 32'd0);
      chk("tmo_mis_clear", 32'(fault_misaligned), 32'd0);
      imem_rsp_valid = 1'b1;
      @(negedge clk);
      imem_rsp_valid = 1'b0;
      chk("tmo_stays_halted", {30'd0, halted, instr_valid}, 32'd2);

      // Response in the 254th wait cycle is accepted normally
      do_reset();
      fetch_one(0, 254, 32'h0, 1'b0);
      chk("late_rsp_no_fault", {30'd0, fault_timeout, halted}, 32'd0);

      // Stalled request, then reset while waiting for a response
      do_reset();
      fetch_one(5, 1, 32'h0, 1'b0);
      retire(0, 1'b1, 32'h40, mem_word(32'h0), 1'b0);
      imem_req_ready = 1'b1;
      @(negedge clk);
      imem_req_ready = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_pc", pc, 32'h0);
      chk("mid_rst_instret", instret, 32'd0);
      chk("mid_rst_instr", instr, 32'd0);
      chk("mid_rst_valid", 32'(instr_valid), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(32'h40);
      @(negedge clk);
      imem_rsp_valid = 1'b0;
      chk("stale_rsp_ignored", 32'(instr_valid), 32'd0);
      fetch_one(0, 1, 32'h0, 1'b0);

      // Randomized run against the program-order model
      do_reset();
      model_pc = 32'h0;
      model_ir = 32'd0;
      for (int n = 0; n < 150; n++) begin
         fetch_one(int'($urandom_range(0, 3)), int'($urandom_range(1, 4)), model_pc, 1'b1);
         chk("rnd_instret", instret, model_ir);
         src = 1'($urandom);
         tmp = $urandom;
         tgt = tmp & 32'hFFFF_FFFC;
         saved_pc = model_pc;
         retire(int'($urandom_range(0, 3)), src, tgt, mem_word(saved_pc), 1'b1);
         model_ir = model_ir + 32'd1;
         model_pc = src ? tgt : saved_pc + 32'd4;
      end
      chk("rnd_final_instret", instret, model_ir);
      chk("rnd_final_no_fault", {29'd0, halted, fault_misaligned, fault_timeout}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
